inst_fetch: RTL and testbench

Instruction fetch stage between program memory and the instruction register. Owns the fetch program counter, issues one memory read at a time, and buffers returned instruction words in a small prefetch queue. Presents them to the IR load path with a valid/ready handshake. A redirect input (branch/jump/reset of PC) flushes the queue and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/inst_fetch.sv | 157 +++++++++++++++
 tb/tb_inst_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_INST_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_INST_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of fetched {addr, data} words.
// A clear request empties the queue and takes priority over push and pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W = 24,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clkin,
  input  logic          Rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Act only on pops that have a word to take and pushes that have room
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
  end

  // Word storage; no reset needed because count gates every read
  always_ff @(posedge clkin) begin
    if (do_push && !clear) begin
      slots[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; clear wins over any push or pop this cycle
  always_ff @(posedge clkin) begin
    if (Rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Present the head word, forced to zero while the queue is empty
  always_comb begin
    head_valid = (count != '0);
    head       = head_valid ? slots[rd_ptr] : '0;
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, single-outstanding memory reader and prefetch queue
// feeding the IR load path. A redirect flushes the queue and drops any
// in-flight response. Define INST_FETCH_STATS_EN to add the fetch/flush
// statistics counters (stat_fetched, stat_flushed).
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int INST_W = DEFAULT_INST_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clkin,
  input  logic              Rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready
`ifdef INST_FETCH_STATS_EN
  ,
  output logic [15:0]       stat_fetched,
  output logic [15:0]       stat_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t             state;
  fetch_state_t             state_next;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        req_addr;
  logic                     push;
  logic                     pop;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_after;
  logic [ADDR_W+INST_W-1:0] head;

  fetch_queue #(
    .DEPTH(DEPTH),
    .W(ADDR_W + INST_W)
  ) u_queue (
    .clkin(clkin),
    .Rst(Rst),
    .clear(redirect),
    .push(push),
    .push_data({req_addr, mem_rdata}),
    .pop(pop),
    .head_valid(inst_valid),
    .head(head),
    .count(count)
  );

  // Split the head entry into the IR-facing address and word
  always_comb begin
    pop       = inst_valid && inst_ready;
    inst_addr = head[ADDR_W+INST_W-1:INST_W];
    inst_data = head[INST_W-1:0];
  end

  // State register
  always_ff @(posedge clkin) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, read strobe and push; redirect overrides every other decision
  always_comb begin
    state_next  = state;
    mem_rd      = 1'b0;
    push        = 1'b0;
    count_after = count + CW'(1) - CW'(pop);
    case (state)
      IDLE: begin
        if (redirect || (count < CW'(DEPTH))) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd     = 1'b1;
        state_next = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_next = mem_rvalid ? ISSUE : DISCARD;
        end else if (mem_rvalid) begin
          push       = 1'b1;
          state_next = (count_after < CW'(DEPTH)) ? ISSUE : IDLE;
        end
      end
      DISCARD: begin
        if (mem_rvalid) begin
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
    mem_addr = mem_rd ? fetch_pc : '0;
  end

  // Fetch PC: loaded by redirect, otherwise advances once per issued read
  always_ff @(posedge clkin) begin
    if (Rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_addr;
    end else if (state == ISSUE) begin
      fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // Remember the address of the outstanding read so its word can be tagged
  always_ff @(posedge clkin) begin
    if (Rst) begin
      req_addr <= '0;
    end else if (state == ISSUE) begin
      req_addr <= fetch_pc;
    end
  end

`ifdef INST_FETCH_STATS_EN
  logic        inflight;
  logic [16:0] flushed_sum;

  // A read is in flight from its issue cycle until its response returns
  always_comb begin
    inflight    = (state == ISSUE) || (state == WAIT);
    flushed_sum = {1'b0, stat_flushed} + 17'(count) + 17'(inflight);
  end

  // Saturating counters of pushed words and words thrown away by redirect
  always_ff @(posedge clkin) begin
    if (Rst) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push && (stat_fetched != 16'hFFFF)) begin
        stat_fetched <= stat_fetched + 16'd1;
      end
      if (redirect) begin
        stat_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch with a latency-configurable
// memory, directed vector tables/sequences and a randomized queue-level model.
`timescale 1ns/1ps
module tb_inst_fetch;
  import fetch_pkg::*;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int DEPTH = 4;
  localparam logic [7:0] RPC = 8'h10;

  logic        clkin = 1'b0;
  logic        Rst;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [7:0]  inst_addr;
  logic        inst_ready;
`ifdef INST_FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_flushed;
`endif

  int nVec = 0;
  int nMis = 0;

  // memory model state
  logic       pend;
  logic       pendStale;
  int         pendCnt;
  logic [7:0] pendAddr;
  logic       rvStale;
  logic [7:0] rvAddr;
  int         fixedLat;
  bit         randLat;

  // queue-level reference model
  fetch_entry_t mq[$];
  logic [7:0]   expPc;
  bit           modelOn;

  inst_fetch #(
    .ADDR_W(AW),
    .INST_W(IW),
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clkin(clkin),
    .Rst(Rst),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .inst_addr(inst_addr),
    .inst_ready(inst_ready)
`ifdef INST_FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  always #5 clkin = ~clkin;

  // program memory contents as a function of address
  function automatic logic [15:0] memWord(input logic [7:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // memory: deliver a due response this cycle, then accept a new read strobe
  task automatic memDrive();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rvStale    = 1'b0;
    if (pend) begin
      pendCnt--;
      if (pendCnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memWord(pendAddr);
        rvStale    = pendStale;
        rvAddr     = pendAddr;
        pend       = 1'b0;
      end
    end
    if (mem_rd) begin
      checkOutput("one_outstanding", {31'd0, pend}, 32'd0);
      pend      = 1'b1;
      pendStale = 1'b0;
      pendAddr  = mem_addr;
      pendCnt   = randLat ? int'($urandom_range(1, 4)) : fixedLat;
    end
  endtask

  task automatic modelUpdate(input logic rdy, input logic redir, input logic [7:0] raddr);
    if (redir) begin
      mq.delete();
      expPc = raddr;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (mem_rvalid && !rvStale) mq.push_back('{addr: rvAddr, data: mem_rdata});
    end
  endtask

  // drive this cycle's inputs at the negedge, then move to the next negedge
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [7:0] raddr);
    inst_ready    = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    memDrive();
    if (redir && pend) pendStale = 1'b1;
    if (modelOn) modelUpdate(rdy, redir, raddr);
    @(negedge clkin);
  endtask

  task automatic doReset();
    Rst           = 1'b1;
    redirect      = 1'b0;
    redirect_addr = '0;
    inst_ready    = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    pend          = 1'b0;
    pendStale     = 1'b0;
    pendCnt       = 0;
    repeat (3) @(negedge clkin);
    Rst = 1'b0;
  endtask

  task automatic checkModel();
    logic ev;
    ev = (mq.size() > 0);
    checkOutput("rnd_valid", {31'd0, inst_valid}, {31'd0, ev});
    if (ev) begin
      checkOutput("rnd_inst_addr", inst_addr, mq[0].addr);
      checkOutput("rnd_inst_data", inst_data, mq[0].data);
    end else begin
      checkOutput("rnd_inst_addr_zero", inst_addr, 0);
      checkOutput("rnd_inst_data_zero", inst_data, 0);
    end
    if (mem_rd) begin
      checkOutput("rnd_mem_addr", mem_addr, expPc);
      expPc = expPc + 8'd1;
      checkOutput("rnd_slot", {31'd0, (mq.size() < DEPTH)}, 32'd1);
    end
  endtask

  typedef struct {
    logic       ready;
    logic       expRd;
    logic [7:0] expAddr;
    logic       expValid;
    logic [7:0] expIAddr;
  } vec_t;

  initial begin
    vec_t       tbl[8];
    int         rdCount;
    logic [7:0] seenAddr;
    logic [7:0] gotAddr[$];
    logic [15:0] gotData[$];
    logic [7:0] expList[4];
    int         pops;
    logic       rdy;
    logic       redir;
    logic [7:0] raddr;

    modelOn  = 0;
    randLat  = 0;
    fixedLat = 1;

    // cycles 1..8 after reset, latency 1, IR always ready
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h10};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b1, 8'h12, 1'b1, 8'h11};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 1'b1, 8'h13, 1'b1, 8'h12};

    // test 1: reset state and streaming fetch
    doReset();
`ifdef INST_FETCH_STATS_EN
    checkOutput("reset_stat_fetched", stat_fetched, 0);
    checkOutput("reset_stat_flushed", stat_flushed, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t1_mem_rd_c%0d", i + 1), {31'd0, mem_rd}, {31'd0, tbl[i].expRd});
      if (tbl[i].expRd) checkOutput($sformatf("t1_mem_addr_c%0d", i + 1), mem_addr, tbl[i].expAddr);
      checkOutput($sformatf("t1_valid_c%0d", i + 1), {31'd0, inst_valid}, {31'd0, tbl[i].expValid});
      checkOutput($sformatf("t1_iaddr_c%0d", i + 1), inst_addr, tbl[i].expIAddr);
      checkOutput($sformatf("t1_idata_c%0d", i + 1), inst_data,
                  tbl[i].expValid ? memWord(tbl[i].expIAddr) : 16'h0);
      applyStimulus(tbl[i].ready, 1'b0, 8'h00);
    end

    // test 2: IR stalled fills exactly DEPTH entries, one pop frees one request
    doReset();
    fixedLat = 1;
    rdCount  = 0;
    for (int c = 0; c < 30; c++) begin
      if (mem_rd) rdCount++;
      applyStimulus(1'b0, 1'b0, 8'h00);
    end
    checkOutput("t2_requests_when_full", rdCount, DEPTH);
    checkOutput("t2_idle_no_rd", {31'd0, mem_rd}, 0);
    checkOutput("t2_head_addr", inst_addr, 8'h10);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t2_head_after_pop", inst_addr, 8'h11);
    rdCount  = 0;
    seenAddr = '0;
    for (int c = 0; c < 10; c++) begin
      if (mem_rd) begin
        rdCount++;
        seenAddr = mem_addr;
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
    end
    checkOutput("t2_requests_after_pop", rdCount, 1);
    checkOutput("t2_refill_addr", seenAddr, 8'h14);

    // test 3: redirect while waiting on a latency-3 response
    doReset();
    fixedLat = 3;
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h40);
    for (int c = 4; c <= 9; c++) begin
      checkOutput($sformatf("t3_valid_c%0d", c), {31'd0, inst_valid}, 0);
      checkOutput($sformatf("t3_mem_rd_c%0d", c), {31'd0, mem_rd}, {31'd0, (c == 6)});
      if (c == 6) checkOutput("t3_mem_addr", mem_addr, 8'h40);
      applyStimulus(1'b1, 1'b0, 8'h00);
    end
    checkOutput("t3_first_valid", {31'd0, inst_valid}, 1);
    checkOutput("t3_first_addr", inst_addr, 8'h40);
    checkOutput("t3_first_data", inst_data, memWord(8'h40));

    // test 4: redirect coinciding with a response and a pop
    doReset();
    fixedLat = 1;
    for (int c = 1; c < 5; c++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t4_pre_valid", {31'd0, inst_valid}, 1);
    checkOutput("t4_pre_rvalid_cycle", {31'd0, mem_rd}, 0);
    applyStimulus(1'b1, 1'b1, 8'h40);
    checkOutput("t4_empty_after", {31'd0, inst_valid}, 0);
    checkOutput("t4_rd_no_discard", {31'd0, mem_rd}, 1);
    checkOutput("t4_rd_addr", mem_addr, 8'h40);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t4_no_stale", {31'd0, inst_valid}, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t4_valid", {31'd0, inst_valid}, 1);
    checkOutput("t4_addr", inst_addr, 8'h40);

    // test 5: fetch address wraps FFh -> 00h
    doReset();
    fixedLat   = 1;
    expList[0] = 8'hFE;
    expList[1] = 8'hFF;
    expList[2] = 8'h00;
    expList[3] = 8'h01;
    applyStimulus(1'b1, 1'b1, 8'hFE);
    for (int c = 0; c < 12; c++) begin
      if (inst_valid) begin
        gotAddr.push_back(inst_addr);
        gotData.push_back(inst_data);
      end
      applyStimulus(1'b1, 1'b0, 8'h00);
    end
    checkOutput("t5_delivered", {31'd0, (gotAddr.size() >= 4)}, 1);
    for (int i = 0; i < 4 && i < gotAddr.size(); i++) begin
      checkOutput($sformatf("t5_addr_%0d", i), gotAddr[i], expList[i]);
      checkOutput($sformatf("t5_data_%0d", i), gotData[i], memWord(expList[i]));
    end

`ifdef INST_FETCH_STATS_EN
    // test 6: statistics after 5 fetches and a flush of 2 queued + 1 in flight
    doReset();
    fixedLat = 1;
    for (int c = 1; c <= 13; c++) begin
      if (c == 12) begin
        checkOutput("t6_fetched_before", stat_fetched, 5);
        applyStimulus(1'b0, 1'b1, 8'h40);
      end else begin
        applyStimulus(c <= 8, 1'b0, 8'h00);
      end
    end
    checkOutput("t6_stat_fetched", stat_fetched, 5);
    checkOutput("t6_stat_flushed", stat_flushed, 3);
`endif

    // test 7: randomized traffic against the queue-level model
    doReset();
    randLat = 1;
    mq.delete();
    expPc   = RPC;
    modelOn = 1;
    pops    = 0;
    for (int c = 0; c < 3000; c++) begin
      checkModel();
      rdy   = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 31) == 0);
      raddr = 8'($urandom_range(0, 255));
      if (inst_valid && rdy && !redir) pops++;
      applyStimulus(rdy, redir, raddr);
    end
    checkOutput("t7_progress", {31'd0, (pops > 100)}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
